// File: rtl/dds_pkg.sv
// ============================================================================
// Module      : dds_pkg
// Description : Shared types and widths for the DDS sweep controller slice:
//               controller state encoding, default widths, DDS control-field
//               widths and waveform-select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

  // Controller state encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Default widths of the frequency word and the dwell counter
  localparam int FW_W_DEF    = 17;
  localparam int DWELL_W_DEF = 16;

  // DDS control-field widths
  localparam int PHASE_W = 12;
  localparam int AMP_W   = 5;
  localparam int WAVE_W  = 2;

  // Waveform-select encodings understood by the DDS core
  localparam logic [WAVE_W-1:0] WAVE_SIN = 2'd0;
  localparam logic [WAVE_W-1:0] WAVE_SQU = 2'd1;
  localparam logic [WAVE_W-1:0] WAVE_TRI = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dds_sweep_ctrl_if.sv
// ============================================================================
// Module      : dds_sweep_ctrl_if
// Description : Sweep-configuration valid/ready bus between the host register
//               block (master) and the sweep controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dds_sweep_ctrl_if #(
  parameter int FW_W    = dds_pkg::FW_W_DEF,
  parameter int DWELL_W = dds_pkg::DWELL_W_DEF
);

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [FW_W-1:0]              cfg_start_word;
  logic [FW_W-1:0]              cfg_stop_word;
  logic [FW_W-1:0]              cfg_step_word;
  logic [DWELL_W-1:0]           cfg_dwell;
  logic [dds_pkg::WAVE_W-1:0]   cfg_wave_c;
  logic [dds_pkg::PHASE_W-1:0]  cfg_p_word;
  logic [dds_pkg::AMP_W-1:0]    cfg_amplitude;

  modport master (
    output cfg_valid, cfg_start_word, cfg_stop_word, cfg_step_word,
           cfg_dwell, cfg_wave_c, cfg_p_word, cfg_amplitude,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_word, cfg_stop_word, cfg_step_word,
           cfg_dwell, cfg_wave_c, cfg_p_word, cfg_amplitude,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/dds_dwell_timer.sv
// ============================================================================
// Module      : dds_dwell_timer
// Description : Loadable down-counter with enable; flags when it sits at zero.
//               Stops at zero until reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] cnt_q;

  assign zero = (cnt_q == '0);

  // Next count: load wins, otherwise count down while enabled and not at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !zero) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency-sweep sequencer for the DDS core. Captures a sweep
//               configuration over valid/ready, then steps f_word from the
//               start word toward the stop word, holding each value for the
//               programmed dwell, and pulses sweep_done on completion.
//               Build option DDS_SWEEP_PINGPONG_EN: sweep endlessly between
//               the two endpoints, pulsing sweep_done at each turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW_W    = FW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  dds_sweep_ctrl_if.slave     cfg,
  input  logic                start,
  input  logic                abort,
  output logic [FW_W-1:0]     f_word,
  output logic [WAVE_W-1:0]   wave_c,
  output logic [PHASE_W-1:0]  p_word,
  output logic [AMP_W-1:0]    amplitude,
  output logic                busy,
  output logic                sweep_done
);

  state_e               state_d,      state_q;
  logic [FW_W-1:0]      f_word_d,     f_word_q;
  logic [WAVE_W-1:0]    wave_c_d,     wave_c_q;
  logic [PHASE_W-1:0]   p_word_d,     p_word_q;
  logic [AMP_W-1:0]     amplitude_d,  amplitude_q;
  logic                 sweep_done_d, sweep_done_q;
  logic [FW_W-1:0]      start_word_d, start_word_q;
  logic [FW_W-1:0]      stop_word_d,  stop_word_q;
  logic [FW_W-1:0]      step_word_d,  step_word_q;
  logic [DWELL_W-1:0]   dwell_d,      dwell_q;
  logic [FW_W-1:0]      tgt_d,        tgt_q;       // endpoint currently swept toward
  logic                 dir_up_d,     dir_up_q;

  logic                 cap;
  logic                 tmr_load;
  logic                 tmr_en;
  logic                 tmr_zero;

  // Next frequency word one step toward target, clamped at the target.
  // The extra top bit catches both overflow (up) and underflow (down).
  function automatic logic [FW_W-1:0] step_to(
    input logic [FW_W-1:0] f,
    input logic [FW_W-1:0] s,
    input logic [FW_W-1:0] t,
    input logic            up
  );
    logic [FW_W:0] n;
    logic [FW_W-1:0] r;
    if (up) begin
      n = {1'b0, f} + {1'b0, s};
      r = (n > {1'b0, t}) ? t : n[FW_W-1:0];
    end else begin
      n = {1'b0, f} - {1'b0, s};
      r = (n[FW_W] || (n[FW_W-1:0] < t)) ? t : n[FW_W-1:0];
    end
    return r;
  endfunction

  assign cap           = cfg.cfg_valid && (state_q == IDLE);
  assign cfg.cfg_ready = (state_q == IDLE);
  assign busy          = (state_q == SWEEP);
  assign f_word        = f_word_q;
  assign wave_c        = wave_c_q;
  assign p_word        = p_word_q;
  assign amplitude     = amplitude_q;
  assign sweep_done    = sweep_done_q;

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .load_val  (dwell_d - DWELL_W'(1)),
    .en        (tmr_en),
    .zero      (tmr_zero)
  );

  // Config capture, sweep sequencing and abort override
  always_comb begin
    state_d      = state_q;
    f_word_d     = f_word_q;
    wave_c_d     = wave_c_q;
    p_word_d     = p_word_q;
    amplitude_d  = amplitude_q;
    sweep_done_d = 1'b0;
    start_word_d = start_word_q;
    stop_word_d  = stop_word_q;
    step_word_d  = step_word_q;
    dwell_d      = dwell_q;
    tgt_d        = tgt_q;
    dir_up_d     = dir_up_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    // A zero amplitude would divide by zero in the DDS; zero dwell is meaningless
    if (cap) begin
      start_word_d = cfg.cfg_start_word;
      stop_word_d  = cfg.cfg_stop_word;
      step_word_d  = cfg.cfg_step_word;
      dwell_d      = (cfg.cfg_dwell == '0) ? DWELL_W'(1) : cfg.cfg_dwell;
      wave_c_d     = cfg.cfg_wave_c;
      p_word_d     = cfg.cfg_p_word;
      amplitude_d  = (cfg.cfg_amplitude == '0) ? AMP_W'(1) : cfg.cfg_amplitude;
    end

    case (state_q)
      IDLE: begin
        // *_word_d already reflect a same-cycle capture
        if (start) begin
          state_d  = SWEEP;
          f_word_d = start_word_d;
          tgt_d    = stop_word_d;
          dir_up_d = (start_word_d <= stop_word_d);
          tmr_load = 1'b1;
        end
      end
      SWEEP: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (f_word_q == tgt_q) begin
            sweep_done_d = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
            tgt_d    = (tgt_q == stop_word_q) ? start_word_q : stop_word_q;
            dir_up_d = ~dir_up_q;
            f_word_d = step_to(f_word_q, step_word_q, tgt_d, dir_up_d);
`else
            state_d  = IDLE;
`endif
          end else begin
            f_word_d = step_to(f_word_q, step_word_q, tgt_q, dir_up_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats start and completion, and suppresses the done pulse
    if (abort) begin
      state_d      = IDLE;
      f_word_d     = '0;
      sweep_done_d = 1'b0;
      tmr_load     = 1'b0;
    end
  end

  // State, output and stored-config registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      f_word_q     <= '0;
      wave_c_q     <= '0;
      p_word_q     <= '0;
      amplitude_q  <= AMP_W'(1);
      sweep_done_q <= 1'b0;
      start_word_q <= '0;
      stop_word_q  <= '0;
      step_word_q  <= '0;
      dwell_q      <= DWELL_W'(1);
      tgt_q        <= '0;
      dir_up_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      f_word_q     <= f_word_d;
      wave_c_q     <= wave_c_d;
      p_word_q     <= p_word_d;
      amplitude_q  <= amplitude_d;
      sweep_done_q <= sweep_done_d;
      start_word_q <= start_word_d;
      stop_word_q  <= stop_word_d;
      step_word_q  <= step_word_d;
      dwell_q      <= dwell_d;
      tgt_q        <= tgt_d;
      dir_up_q     <= dir_up_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ============================================================================
// Module      : tb_dds_sweep_ctrl
// Description : Directed self-checking bench for dds_sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [16:0] f_word;
  logic [1:0]  wave_c;
  logic [11:0] p_word;
  logic [4:0]  amplitude;
  logic        busy;
  logic        sweep_done;

  int total = 0;
  int bad   = 0;

  dds_sweep_ctrl_if #(.FW_W(17), .DWELL_W(16)) cfg_if ();

  dds_sweep_ctrl #(.FW_W(17), .DWELL_W(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg        (cfg_if),
    .start      (start),
    .abort      (abort),
    .f_word     (f_word),
    .wave_c     (wave_c),
    .p_word     (p_word),
    .amplitude  (amplitude),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance to 1 time unit past the next rising edge
  task automatic step_clk();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [16:0] s, input logic [16:0] e, input logic [16:0] st,
                         input logic [15:0] dw, input logic [1:0] wc,
                         input logic [11:0] pw, input logic [4:0] am);
    cfg_if.cfg_start_word = s;
    cfg_if.cfg_stop_word  = e;
    cfg_if.cfg_step_word  = st;
    cfg_if.cfg_dwell      = dw;
    cfg_if.cfg_wave_c     = wc;
    cfg_if.cfg_p_word     = pw;
    cfg_if.cfg_amplitude  = am;
  endtask

  task automatic test_reset();
    cfg_if.cfg_valid = 1'b0;
    set_cfg(17'd0, 17'd0, 17'd0, 16'd0, 2'd0, 12'd0, 5'd0);
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step_clk();
    total++;
    if (f_word !== 17'd0 || amplitude !== 5'd1 || cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0 ||
        sweep_done !== 1'b0 || wave_c !== 2'd0 || p_word !== 12'd0) begin
      bad++;
      $display("FAIL reset f=%0d amp=%0d rdy=%b busy=%b done=%b wave=%0d p=%0d expected 0 1 1 0 0 0 0",
               f_word, amplitude, cfg_if.cfg_ready, busy, sweep_done, wave_c, p_word);
    end
  endtask

  task automatic test_up_sweep();
    logic [16:0] exp_f;
    set_cfg(17'd100, 17'd130, 17'd10, 16'd4, 2'd2, 12'h123, 5'd7);
    cfg_if.cfg_valid = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (wave_c !== 2'd2 || p_word !== 12'h123 || amplitude !== 5'd7 || busy !== 1'b0) begin
      bad++;
      $display("FAIL up_cfg wave=%0d p=%h amp=%0d busy=%b expected wave=2 p=123 amp=7 busy=0",
               wave_c, p_word, amplitude, busy);
    end
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      exp_f = 17'd100 + 17'(10 * ((k - 1) / 4));
      total++;
      if (f_word !== exp_f || busy !== 1'b1 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL up_seq cyc=%0d f=%0d busy=%b done=%b expected f=%0d busy=1 done=0",
                 k, f_word, busy, sweep_done, exp_f);
      end
      step_clk();
    end
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1 || f_word !== 17'd130) begin
      bad++;
      $display("FAIL up_done cyc=17 done=%b busy=%b rdy=%b f=%0d expected 1 0 1 130",
               sweep_done, busy, cfg_if.cfg_ready, f_word);
    end
    step_clk();
    total++;
    if (sweep_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL up_done_width done=%b busy=%b expected 0 0", sweep_done, busy);
    end
  endtask

  // Config and start in the same cycle: the new config must be used
  task automatic test_overshoot();
    logic [16:0] exp_f;
    set_cfg(17'h1FFF0, 17'h1FFFF, 17'h00020, 16'd2, 2'd1, 12'h0, 5'd3);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_f = (k <= 2) ? 17'h1FFF0 : 17'h1FFFF;
      total++;
      if (f_word !== exp_f || busy !== 1'b1 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL ovs_seq cyc=%0d f=%h busy=%b done=%b expected f=%h busy=1 done=0",
                 k, f_word, busy, sweep_done, exp_f);
      end
      step_clk();
    end
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || f_word !== 17'h1FFFF) begin
      bad++;
      $display("FAIL ovs_done done=%b busy=%b f=%h expected 1 0 1ffff", sweep_done, busy, f_word);
    end
  endtask

  task automatic test_down_sweep();
    logic [16:0] exp_seq [3];
    exp_seq[0] = 17'd50; exp_seq[1] = 17'd30; exp_seq[2] = 17'd20;
    set_cfg(17'd50, 17'd20, 17'd20, 16'd1, 2'd0, 12'h0, 5'd2);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (f_word !== exp_seq[k] || busy !== 1'b1 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL down_seq idx=%0d f=%0d busy=%b done=%b expected f=%0d busy=1 done=0",
                 k, f_word, busy, sweep_done, exp_seq[k]);
      end
      step_clk();
    end
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || f_word !== 17'd20) begin
      bad++;
      $display("FAIL down_done done=%b busy=%b f=%0d expected 1 0 20", sweep_done, busy, f_word);
    end
  endtask

  task automatic test_zero_cfg();
    set_cfg(17'd5, 17'd7, 17'd1, 16'd0, 2'd0, 12'h0, 5'd0);
    cfg_if.cfg_valid = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (amplitude !== 5'd1) begin
      bad++;
      $display("FAIL zero_amp amplitude=%0d expected 1", amplitude);
    end
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (f_word !== 17'(5 + k) || busy !== 1'b1) begin
        bad++;
        $display("FAIL zero_dwell idx=%0d f=%0d busy=%b expected f=%0d busy=1", k, f_word, busy, 5 + k);
      end
      step_clk();
    end
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done done=%b busy=%b expected 1 0", sweep_done, busy);
    end
  endtask

  task automatic test_degenerate();
    // Equal endpoints: one dwell period then done
    set_cfg(17'd77, 17'd77, 17'd5, 16'd3, 2'd0, 12'h0, 5'd1);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (f_word !== 17'd77 || busy !== 1'b1 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL equal_seq cyc=%0d f=%0d busy=%b done=%b expected 77 1 0", k, f_word, busy, sweep_done);
      end
      step_clk();
    end
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL equal_done done=%b busy=%b expected 1 0", sweep_done, busy);
    end
    // Zero step: parked at start word until abort
    set_cfg(17'd40, 17'd50, 17'd0, 16'd1, 2'd0, 12'h0, 5'd1);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (f_word !== 17'd40 || busy !== 1'b1 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL step0_seq cyc=%0d f=%0d busy=%b done=%b expected 40 1 0", k, f_word, busy, sweep_done);
      end
      step_clk();
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || f_word !== 17'd0 || sweep_done !== 1'b0) begin
      bad++;
      $display("FAIL step0_abort busy=%b f=%0d done=%b expected 0 0 0", busy, f_word, sweep_done);
    end
  endtask

  // Config offered mid-sweep is held off, start mid-sweep is ignored
  task automatic test_holdoff();
    logic [16:0] exp_f;
    set_cfg(17'd10, 17'd12, 17'd1, 16'd2, 2'd3, 12'h0F0, 5'd4);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    start = 1'b1;
    set_cfg(17'd900, 17'd990, 17'd3, 16'd6, 2'd0, 12'h055, 5'd3);
    for (int k = 1; k <= 6; k++) begin
      exp_f = 17'd10 + 17'((k - 1) / 2);
      total++;
      if (f_word !== exp_f || cfg_if.cfg_ready !== 1'b0 || wave_c !== 2'd3 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_seq cyc=%0d f=%0d rdy=%b wave=%0d busy=%b expected f=%0d rdy=0 wave=3 busy=1",
                 k, f_word, cfg_if.cfg_ready, wave_c, busy, exp_f);
      end
      step_clk();
      start = 1'b0;
    end
    total++;
    if (sweep_done !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || wave_c !== 2'd3) begin
      bad++;
      $display("FAIL hold_done done=%b rdy=%b wave=%0d expected 1 1 3", sweep_done, cfg_if.cfg_ready, wave_c);
    end
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (wave_c !== 2'd0 || p_word !== 12'h055 || amplitude !== 5'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_capture wave=%0d p=%h amp=%0d busy=%b expected 0 055 3 0",
               wave_c, p_word, amplitude, busy);
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    logic [16:0] exp_f;
    set_cfg(17'd200, 17'd1000, 17'd1, 16'd3, 2'd2, 12'h0, 5'd5);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_f = (k <= 3) ? 17'd200 : 17'd201;
      total++;
      if (f_word !== exp_f || busy !== 1'b1) begin
        bad++;
        $display("FAIL abort_pre cyc=%0d f=%0d busy=%b expected f=%0d busy=1", k, f_word, busy, exp_f);
      end
      if (k < 5) step_clk();
    end
    abort = 1'b1;
    start = 1'b1;
    step_clk();
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (f_word !== 17'd0 || busy !== 1'b0 || sweep_done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_next f=%0d busy=%b done=%b rdy=%b expected 0 0 0 1",
               f_word, busy, sweep_done, cfg_if.cfg_ready);
    end
    set_cfg(17'd1, 17'd2, 17'd1, 16'd1, 2'd1, 12'hABC, 5'd9);
    cfg_if.cfg_valid = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (wave_c !== 2'd1 || p_word !== 12'hABC || amplitude !== 5'd9) begin
      bad++;
      $display("FAIL abort_recfg wave=%0d p=%h amp=%0d expected 1 abc 9", wave_c, p_word, amplitude);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sweep_done === 1'b1 || busy !== 1'b0) seen_done = 1'b1;
      step_clk();
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet done_or_busy_seen=%b expected 0", seen_done);
    end
  endtask

  task automatic test_async_reset();
    set_cfg(17'd300, 17'd400, 17'd1, 16'd5, 2'd2, 12'h777, 5'd6);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    step_clk();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    step_clk();
    step_clk();
    #2;
    sys_rst_n = 1'b0;
    #1;
    total++;
    if (f_word !== 17'd0 || busy !== 1'b0 || amplitude !== 5'd1 || wave_c !== 2'd0 ||
        p_word !== 12'd0 || cfg_if.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_rst f=%0d busy=%b amp=%0d wave=%0d p=%0d rdy=%b expected 0 0 1 0 0 1",
               f_word, busy, amplitude, wave_c, p_word, cfg_if.cfg_ready);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    // Stored config is back to start=stop=0, dwell=1: one cycle at 0 then done
    start = 1'b1;
    step_clk();
    start = 1'b0;
    total++;
    if (f_word !== 17'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_cfg_run f=%0d busy=%b expected 0 1", f_word, busy);
    end
    step_clk();
    total++;
    if (sweep_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_cfg_done done=%b busy=%b expected 1 0", sweep_done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_overshoot();
    test_down_sweep();
    test_zero_cfg();
    test_degenerate();
    test_holdoff();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Programmable frequency-sweep sequencer driving the control inputs (f_word, wave_c, p_word, amplitude) of the DDS waveform generator. It accepts a sweep configuration over a valid/ready handshake. On a start command it steps the frequency word from a start value toward a stop value, holding each step for a programmable number of clock cycles. It then reports completion. It sits between the host/register interface and the DDS core, in the same sys_clk domain.

## Interface
Parameters:
- FW_W, 17, frequency-word width (matches DDS f_word)
- DWELL_W, 16, dwell-counter width

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  configuration word valid
- cfg_ready  out  1  controller can accept configuration
- cfg_start_word  in  FW_W  first frequency word of sweep
- cfg_stop_word  in  FW_W  final frequency word of sweep
- cfg_step_word  in  FW_W  frequency increment per step, unsigned
- cfg_dwell  in  DWELL_W  cycles to hold each frequency
- cfg_wave_c  in  2  waveform select passed to DDS
- cfg_p_word  in  12  phase offset passed to DDS
- cfg_amplitude  in  5  amplitude divisor passed to DDS
- start  in  1  single-cycle sweep start command
- abort  in  1  single-cycle sweep abort command
- f_word  out  FW_W  DDS frequency word, registered
- wave_c  out  2  DDS waveform select, registered
- p_word  out  12  DDS phase offset, registered
- amplitude  out  5  DDS amplitude divisor, registered, never 0
- busy  out  1  high in SWEEP state
- sweep_done  out  1  one-cycle pulse when sweep completes

## Operation
- Configuration is captured on the cycle where cfg_valid && cfg_ready.
- cfg_ready is 1 in IDLE and 0 in SWEEP.
- wave_c, p_word and amplitude update on the cycle after capture.
- cfg_amplitude = 0 is stored as 1. This prevents a divide-by-zero in the DDS.
- cfg_dwell = 0 is stored as 1.
- Direction is fixed at start: up if start_word <= stop_word, otherwise down.
- States:
  - IDLE: f_word holds its last value.
    - On start → SWEEP: f_word = start_word, dwell counter = dwell − 1.
    - If start and a config handshake occur in the same cycle, the new config is used.
  - SWEEP: the counter decrements each cycle.
    - At counter 0, next = f_word ± step, computed at FW_W+1 bits.
    - If next passes stop_word (up: next > stop; down: next underflows or next < stop), f_word = stop_word and the sweep enters a final dwell.
    - Otherwise f_word = next and the counter reloads.
    - When the counter reaches 0 with f_word == stop_word: pulse sweep_done → IDLE.
- start_word == stop_word: one dwell period at start_word, then done.
- step = 0 with start != stop: f_word stays at start_word until abort.
- abort in any state: next cycle state = IDLE, f_word = 0, sweep_done is not pulsed.
- abort has priority over start and over sweep completion.
- start while in SWEEP is ignored.
- cfg_valid while in SWEEP is held off (cfg_ready = 0). It is never dropped.

## Timing
- Reset values:
  - f_word = 0, wave_c = 0, p_word = 0, amplitude = 1
  - busy = 0, sweep_done = 0, cfg_ready = 1
  - stored config: start = stop = step = 0, dwell = 1
- Start latency: start at cycle N → f_word = start_word and busy = 1 at N+1.
- Each frequency value is held for exactly dwell cycles, including the first and the last.
- sweep_done is high for exactly one cycle, the first IDLE cycle. In that same cycle busy = 0 and cfg_ready = 1.
- Total sweep length = dwell × (number of distinct frequency values).
- Reset asserted mid-sweep returns all outputs to their reset values asynchronously.

## Configuration
- DDS_SWEEP_PINGPONG_EN:
  - Defined: on reaching stop_word after the final dwell, the direction reverses and the sweep runs back to start_word, then reverses again. This repeats indefinitely. sweep_done pulses at every endpoint turnaround, busy stays 1, and only abort exits.
  - Undefined: single sweep as described above.

## Structure
- Shared package dds_pkg holds:
  - state enum (IDLE, SWEEP)
  - FW_W / DWELL_W defaults
  - DDS parameter widths (12-bit phase, 5-bit amplitude, 2-bit wave select)
  - wave_c encodings: SIN = 0, SQU = 1, TRI = 2
- One natural sub-module: dds_dwell_timer, a loadable down-counter with load, enable and zero flag.

## Test plan
- Reset then idle: f_word = 0, amplitude = 1, cfg_ready = 1, busy = 0.
- Up sweep with start = 100, stop = 130, step = 10, dwell = 4: f_word reads 100, 110, 120, 130 for 4 cycles each. sweep_done pulses at cycle 17 after start, then the block returns to IDLE.
- Overshoot clamp with start = 0x1FFF0, stop = 0x1FFFF, step = 0x20, dwell = 2: f_word reads 0x1FFF0, 0x1FFFF, then done. No wrap to a small value.
- Down sweep with start = 50, stop = 20, step = 20, dwell = 1: f_word reads 50, 30, 20, then done.
- cfg_amplitude = 0 and cfg_dwell = 0: amplitude output = 1, and each step is held for 1 cycle.
- Abort at cycle 5 of a sweep, asserted together with start: next cycle f_word = 0 and busy = 0, sweep_done never pulses, and a subsequent config handshake is accepted immediately.
